// File: rtl/countdown_mmss_timer.sv
// Irrigation-duration countdown timer: MM:SS held as four BCD digits, decremented once per
// PRESCALE clock cycles while running, with load/start/stop control and an expiry pulse.
module countdown_mmss_timer #(
    parameter int PRESCALE   = 50_000_000,
    parameter int PRESCALE_W = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] time_bus,
    output logic        running,
    output logic        done,
    output logic        load_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [PRESCALE_W-1:0] PRESC_MAX = PRESCALE_W'(PRESCALE - 1);

    state_t                state_q, state_d;
    logic [15:0]           time_q, time_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  running_q, done_q, done_d, lerr_q, lerr_d;
    logic                  tick;
    logic [15:0]           dec_val;

    function automatic logic load_ok(input logic [15:0] v);
        return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
               (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // One-second decrement with borrow rippling s_units -> s_tens -> m_units -> m_tens.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        logic       b;
        mt = t[15:12];
        mu = t[11:8];
        st = t[7:4];
        su = t[3:0];
        b  = (su == 4'd0);
        su = b ? 4'd9 : su - 4'd1;
        if (b) begin
            b  = (st == 4'd0);
            st = b ? 4'd5 : st - 4'd1;
        end
        if (b) begin
            b  = (mu == 4'd0);
            mu = b ? 4'd9 : mu - 4'd1;
        end
        if (b) begin
            mt = mt - 4'd1;
        end
        return {mt, mu, st, su};
    endfunction

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        lerr_d  = 1'b0;
        tick    = (state_q == RUN) && (presc_q == PRESC_MAX);
        dec_val = bcd_dec(time_q);
        case (state_q)
            RUN: begin
                // The prescaler advances on every RUN cycle, including the one that pauses.
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    time_d = dec_val;
                end
                if (tick && (dec_val == 16'h0000)) begin
                    state_d = EXPIRED;
                    done_d  = 1'b1;
                end else if (stop) begin
                    state_d = PAUSE;
                end
            end
            default: begin
                if (load) begin
                    if (load_ok(load_value)) begin
                        time_d  = load_value;
                        presc_d = '0;
                        state_d = IDLE;
                    end else begin
                        lerr_d = 1'b1;
                    end
                end else if (start && (time_q != 16'h0000) && (state_q != EXPIRED)) begin
                    state_d = RUN;
                    if (state_q == IDLE) begin
                        presc_d = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            time_q    <= 16'h0000;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            lerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            presc_q   <= presc_d;
            running_q <= (state_d == RUN);
            done_q    <= done_d;
            lerr_q    <= lerr_d;
        end
    end

    assign time_bus   = time_q;
    assign running    = running_q;
    assign done       = done_q;
    assign load_error = lerr_q;

endmodule

// File: tb/tb_countdown_mmss_timer.sv
// Bench for countdown_mmss_timer: a seconds-based reference model plus directed and random scenarios.
module tb_countdown_mmss_timer;

    localparam int PRESCALE = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0, start = 1'b0, stop = 1'b0;
    logic [15:0] load_value = 16'h0000;
    logic [15:0] time_bus;
    logic        running, done, load_error;

    int checks = 0;
    int errors = 0;

    // Reference state: remaining time as a plain number of seconds.
    int   m_secs  = 0;
    int   m_state = S_IDLE;
    int   m_pre   = 0;
    logic m_done  = 1'b0;
    logic m_lerr  = 1'b0;

    typedef struct packed {
        logic        rst;
        logic        ld;
        logic [15:0] lv;
        logic        st;
        logic        sp;
    } op_t;

    countdown_mmss_timer #(.PRESCALE(PRESCALE), .PRESCALE_W(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .time_bus   (time_bus),
        .running    (running),
        .done       (done),
        .load_error (load_error)
    );

    always #5 clock = ~clock;

    function automatic op_t mk(logic rst, logic ld, logic [15:0] lv, logic st, logic sp);
        return {rst, ld, lv, st, sp};
    endfunction

    function automatic op_t idle();
        return mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endfunction

    function automatic bit valid_bcd(input logic [15:0] v);
        return (v[15:12] < 10) && (v[11:8] < 10) && (v[7:4] < 6) && (v[3:0] < 10);
    endfunction

    function automatic int from_bcd(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [18:0] exp_vec();
        return {to_bcd(m_secs), (m_state == S_RUN), m_done, m_lerr};
    endfunction

    task automatic model_step(input op_t o);
        m_done = 1'b0;
        m_lerr = 1'b0;
        if (o.rst) begin
            m_secs  = 0;
            m_state = S_IDLE;
            m_pre   = 0;
        end else if (m_state != S_RUN && o.ld) begin
            if (valid_bcd(o.lv)) begin
                m_secs  = from_bcd(o.lv);
                m_pre   = 0;
                m_state = S_IDLE;
            end else begin
                m_lerr = 1'b1;
            end
        end else if (m_state == S_RUN) begin
            m_pre++;
            if (m_pre == PRESCALE) begin
                m_pre = 0;
                m_secs--;
            end
            if (m_secs == 0) begin
                m_state = S_EXP;
                m_done  = 1'b1;
            end else if (o.sp) begin
                m_state = S_PAUSE;
            end
        end else if (o.st && m_secs != 0 && (m_state == S_IDLE || m_state == S_PAUSE)) begin
            if (m_state == S_IDLE) m_pre = 0;
            m_state = S_RUN;
        end
    endtask

    task automatic cyc(input op_t o);
        reset = o.rst; load = o.ld; load_value = o.lv; start = o.st; stop = o.sp;
        @(posedge clock);
        model_step(o);
        #1;
        reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset();
        op_t q[$];
        logic [18:0] got;
        q.push_back(mk(1'b1, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)));
        q.push_back(mk(1'b1, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)));
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        foreach (q[i]) begin
            cyc(q[i]);
            got = {time_bus, running, done, load_error};
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL reset[%0d] model: got %h exp %h", i, got, exp_vec());
            end
            if (i == 1) begin
                checks++;
                if (got !== 19'h0) begin
                    errors++;
                    $display("FAIL reset_values: got %h exp 00000", got);
                end
            end
            if (i == 2) begin
                checks++;
                if (running !== 1'b0) begin
                    errors++;
                    $display("FAIL start_without_load: running %b exp 0", running);
                end
            end
        end
    endtask

    task automatic test_borrow();
        op_t q[$];
        logic [18:0] got;
        q.push_back(mk(1'b0, 1'b1, 16'h0102, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        for (int k = 0; k < 12; k++) q.push_back(idle());
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1));
        q.push_back(mk(1'b0, 1'b1, 16'h1000, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        for (int k = 0; k < 4; k++) q.push_back(idle());
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1));
        foreach (q[i]) begin
            cyc(q[i]);
            got = {time_bus, running, done, load_error};
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL borrow[%0d] model: got %h exp %h", i, got, exp_vec());
            end
            if (i == 5 || i == 9 || i == 13 || i == 20) begin
                logic [15:0] want;
                want = (i == 5) ? 16'h0101 : (i == 9) ? 16'h0100 : (i == 13) ? 16'h0059 : 16'h0959;
                checks++;
                if (time_bus !== want) begin
                    errors++;
                    $display("FAIL borrow_value[%0d]: got %h exp %h", i, time_bus, want);
                end
            end
        end
    endtask

    task automatic test_expiry();
        op_t q[$];
        logic [18:0] got;
        q.push_back(mk(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        for (int k = 0; k < 8; k++) q.push_back(idle());
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0));
        foreach (q[i]) begin
            cyc(q[i]);
            got = {time_bus, running, done, load_error};
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL expiry[%0d] model: got %h exp %h", i, got, exp_vec());
            end
            if (i == 5 || i == 9 || i == 10 || i == 11) begin
                logic [18:0] want;
                want = (i == 5) ? {16'h0001, 3'b100} : (i == 9) ? {16'h0000, 3'b010} :
                       (i == 10) ? {16'h0000, 3'b000} : {16'h0005, 3'b000};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL expiry_point[%0d]: got %h exp %h", i, got, want);
                end
            end
        end
    endtask

    task automatic test_validation();
        op_t q[$];
        logic [18:0] got;
        q.push_back(mk(1'b0, 1'b1, 16'h0060, 1'b0, 1'b0));
        q.push_back(idle());
        q.push_back(mk(1'b0, 1'b1, 16'h00A0, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        q.push_back(idle());
        q.push_back(mk(1'b0, 1'b1, 16'h0030, 1'b0, 1'b0));
        for (int k = 0; k < 4; k++) q.push_back(idle());
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1));
        foreach (q[i]) begin
            cyc(q[i]);
            got = {time_bus, running, done, load_error};
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL validation[%0d] model: got %h exp %h", i, got, exp_vec());
            end
            if (i == 0 || i == 1 || i == 2 || i == 5 || i == 7) begin
                logic [18:0] want;
                want = (i == 0 || i == 2) ? {16'h0005, 3'b001} : (i == 1) ? {16'h0005, 3'b000} :
                       (i == 5) ? {16'h0005, 3'b100} : {16'h0004, 3'b100};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL validation_point[%0d]: got %h exp %h", i, got, want);
                end
            end
        end
    endtask

    task automatic test_pause();
        op_t q[$];
        logic [18:0] got;
        q.push_back(mk(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        q.push_back(idle());
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1));
        for (int k = 0; k < 10; k++) q.push_back(idle());
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        q.push_back(idle());
        q.push_back(idle());
        foreach (q[i]) begin
            cyc(q[i]);
            got = {time_bus, running, done, load_error};
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL pause[%0d] model: got %h exp %h", i, got, exp_vec());
            end
            if (i >= 3) begin
                logic [18:0] want;
                want = (i <= 13) ? {16'h0010, 3'b000} : (i == 14 || i == 15) ? {16'h0010, 3'b100} :
                       {16'h0009, 3'b100};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL pause_point[%0d]: got %h exp %h", i, got, want);
                end
            end
        end
    endtask

    task automatic test_priority();
        op_t q[$];
        logic [18:0] got;
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1));
        q.push_back(mk(1'b0, 1'b1, 16'h0003, 1'b1, 1'b0));
        q.push_back(idle());
        q.push_back(mk(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        for (int k = 0; k < 13; k++) q.push_back(idle());
        q.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        for (int k = 0; k < 5; k++) q.push_back(idle());
        foreach (q[i]) begin
            cyc(q[i]);
            got = {time_bus, running, done, load_error};
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL priority[%0d] model: got %h exp %h", i, got, exp_vec());
            end
            if (i == 1 || i == 2 || i == 3 || i == 17 || i >= 19) begin
                logic [18:0] want;
                want = (i == 1) ? {16'h0009, 3'b000} : (i == 2 || i == 3) ? {16'h0003, 3'b000} :
                       (i == 17) ? {16'h0007, 3'b100} : {16'h0000, 3'b000};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL priority_point[%0d]: got %h exp %h", i, got, want);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [18:0] got;
        op_t o;
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            o = idle();
            if (r < 2) begin
                o.rst = 1'b1;
            end else if (r < 14) begin
                o.ld = 1'b1;
                o.lv = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
                o.st = 1'($urandom_range(0, 3) == 0);
            end else if (r < 18) begin
                o.ld = 1'b1;
                o.lv = 16'($urandom);
            end else if (r < 32) begin
                o.st = 1'b1;
            end else if (r < 38) begin
                o.sp = 1'b1;
            end else if (r < 41) begin
                o.st = 1'b1;
                o.sp = 1'b1;
            end
            cyc(o);
            got = {time_bus, running, done, load_error};
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d] model: got %h exp %h", i, got, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_borrow();
        test_expiry();
        test_validation();
        test_pause();
        test_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
